// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   state_e    - transmitter FSM states
//   PAR_*      - parity selection encoding for P_PARITY
//   frame_len  - clk cycles in one complete frame for a parameter set
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int frame_len(int clks_per_bit, int data_bits, int parity, int stop_bits);
        return clks_per_bit * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte stream feeding the transmitter.
//   s_data - byte to send (FIFO rd_data)
//   s_vld  - s_data valid (FIFO rd_vld)
//   s_rdy  - consumer accepts s_data this cycle (FIFO rd_rdy)
// master = producer (FIFO read side), slave = uart_tx.
interface uart_tx_if #(
    parameter int P_DATA_BITS = 8
);
    logic [P_DATA_BITS-1:0] s_data;
    logic                   s_vld;
    logic                   s_rdy;

    modport master (output s_data, output s_vld, input s_rdy);
    modport slave  (input s_data, input s_vld, output s_rdy);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: bit-period timer for the UART transmitter.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - forces the count back to 0 on the next edge
//   bit_done   - high on the last cycle of a bit period (count == P_CLKS_PER_BIT-1)
//   cnt        - current count, 0..P_CLKS_PER_BIT-1
module baud_gen #(
    parameter int P_CLKS_PER_BIT = 868,
    parameter int P_CNT_W        = $clog2(P_CLKS_PER_BIT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    output logic               bit_done,
    output logic [P_CNT_W-1:0] cnt
);

    logic [P_CNT_W-1:0] cnt_q, cnt_d;

    assign bit_done = (cnt_q == P_CNT_W'(P_CLKS_PER_BIT - 1));
    assign cnt      = cnt_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_done) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART frame transmitter draining a valid/ready byte stream.
//   clk, rst_n - transmit clock, asynchronous active-low reset
//   s          - uart_tx_if.slave: s_data / s_vld in, s_rdy out (registered)
//   tx         - serial line, idle high (registered)
//   busy       - frame in progress (registered)
// Frame: start, P_DATA_BITS data LSB first, optional parity, P_STOP_BITS stops.
// A new byte may be accepted on the last cycle of the last stop bit so that
// back-to-back frames leave no idle gap on the line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int P_CLKS_PER_BIT = 868,
    parameter int P_DATA_BITS    = 8,
    parameter int P_PARITY       = 0,
    parameter int P_STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   s,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = $clog2(P_CLKS_PER_BIT);

    if (P_CLKS_PER_BIT < 2 || P_DATA_BITS < 5 || P_DATA_BITS > 9 ||
        P_PARITY < PAR_NONE || P_PARITY > PAR_ODD ||
        P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : g_bad_param
        $error("uart_tx: illegal parameter value");
    end

    state_e                 state_q, state_d;
    logic [P_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   s_rdy_q, s_rdy_d;
    logic                   xfer;
    logic                   bit_done;
    logic                   baud_clear;
    logic [CNT_W-1:0]       baud_cnt;

    // Timer restarts on every state change and is held at 0 while idle so the
    // start bit gets a full period from the handshake edge.
    assign baud_clear = (state_d != state_q) || (state_q == IDLE);

    baud_gen #(
        .P_CLKS_PER_BIT (P_CLKS_PER_BIT),
        .P_CNT_W        (CNT_W)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .bit_done (bit_done),
        .cnt      (baud_cnt)
    );

    assign xfer    = s.s_vld && s_rdy_q;
    assign s.s_rdy = s_rdy_q;
    assign tx      = tx_q;
    assign busy    = busy_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = START;
                    shreg_d = s.s_data;
                    par_d   = (P_PARITY == PAR_ODD) ? ~^s.s_data : ^s.s_data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 4'(P_DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (P_PARITY != PAR_NONE) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Next data bit is the one just above the current LSB.
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (bit_idx_q == 4'(P_STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (xfer) begin
                            state_d = START;
                            shreg_d = s.s_data;
                            par_d   = (P_PARITY == PAR_ODD) ? ~^s.s_data : ^s.s_data;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // s_rdy is a flop, so it is raised one cycle early: when the timer
        // sits one short of the end of the final stop bit.
        s_rdy_d = (state_d == IDLE) ||
                  ((state_q == STOP) && (bit_idx_q == 4'(P_STOP_BITS - 1)) &&
                   (baud_cnt == CNT_W'(P_CLKS_PER_BIT - 2)));
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            s_rdy_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            s_rdy_q   <= s_rdy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four transmitters (no parity, even, odd, two stop bits) driven
// side by side. A queue-of-line-levels model predicts tx/busy/s_rdy every
// cycle; directed literal expectations pin the model on the reference frames.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int N   = 4;
    localparam int PAR_T [N] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
    localparam int STP_T [N] = '{1, 1, 1, 2};

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] vld   = '0;
    logic [7:0]   dat [N];
    logic [N-1:0] rdy_w, tx_w, busy_w;

    int chk = 0;
    int err = 0;
    int cyc = 0;
    int hs0 = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx_if #(.P_DATA_BITS(DB)) bus ();
        assign bus.s_vld  = vld[g];
        assign bus.s_data = dat[g];
        assign rdy_w[g]   = bus.s_rdy;

        uart_tx #(
            .P_CLKS_PER_BIT (CPB),
            .P_DATA_BITS    (DB),
            .P_PARITY       (PAR_T[g]),
            .P_STOP_BITS    (STP_T[g])
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .s     (bus),
            .tx    (tx_w[g]),
            .busy  (busy_w[g])
        );
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // lvq[g] holds the line level for each upcoming cycle of the frame(s)
    // in flight; empty means idle. Ready when idle or one cycle from empty.
    bit           lvq [N][$];
    logic [N-1:0] mrdy = '0;
    int           xcnt [N] = '{0, 0, 0, 0};

    task automatic push_bit(int g, bit b);
        for (int k = 0; k < CPB; k++) lvq[g].push_back(b);
    endtask

    task automatic push_frame(int g, logic [7:0] d);
        push_bit(g, 1'b0);
        for (int i = 0; i < DB; i++) push_bit(g, d[i]);
        if (PAR_T[g] == PAR_EVEN) push_bit(g, ^d);
        if (PAR_T[g] == PAR_ODD)  push_bit(g, ~^d);
        for (int i = 0; i < STP_T[g]; i++) push_bit(g, 1'b1);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (clk) cyc++;
        if (!rst_n) begin
            for (int g = 0; g < N; g++) begin
                lvq[g].delete();
                mrdy[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < N; g++) begin
                bit xf;
                xf = vld[g] && mrdy[g];
                if (lvq[g].size() > 0) void'(lvq[g].pop_front());
                if (xf) begin
                    push_frame(g, dat[g]);
                    xcnt[g]++;
                end
                mrdy[g] = (lvq[g].size() <= 1);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            logic et;
            et = (lvq[g].size() != 0) ? lvq[g][0] : 1'b1;
            check($sformatf("tx[%0d]", g), 32'(tx_w[g]), 32'(et));
            check($sformatf("busy[%0d]", g), 32'(busy_w[g]), 32'(lvq[g].size() != 0));
            check($sformatf("rdy[%0d]", g), 32'(rdy_w[g]), 32'(mrdy[g]));
        end
        if (vld[0] && rdy_w[0]) hs0++;
    end

    // Waits (bounded) until the model records a new transfer on instance g.
    task automatic wait_xfer(int g);
        int base;
        int n;
        base = xcnt[g];
        n = 0;
        while (xcnt[g] == base && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("xfer_seen[%0d]", g), 32'(xcnt[g] != base), 32'd1);
    endtask

    logic       s_tx   [N][44];
    logic       s_busy [N][44];
    logic       s_rdy0 [44];
    logic [9:0] pat;

    initial begin
        int c1, c2, h0, cnt, b1, b2, b3;
        for (int g = 0; g < N; g++) dat[g] = 8'h00;
        pat = 10'b1101001010;  // 0xA5 frame: 0,1,0,1,0,0,1,0,1,1 from index 0

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rdy_after_release", 32'(rdy_w), 32'h0);
        repeat (2) @(posedge clk);

        // --- reference frames on all four instances ---
        @(posedge clk); #1;
        dat = '{8'hA5, 8'h07, 8'h07, 8'h3C};
        vld = '1;
        wait_xfer(0);
        vld = '0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                s_tx[g][k]   = tx_w[g];
                s_busy[g][k] = busy_w[g];
            end
            s_rdy0[k] = rdy_w[0];
        end
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < CPB; j++)
                check($sformatf("a5_bit%0d_cyc%0d", i, j), 32'(s_tx[0][4*i+j]), 32'(pat[i]));
        cnt = 0;
        for (int k = 0; k < 39; k++) cnt += (s_rdy0[k] == 1'b1) ? 1 : 0;
        check("a5_rdy_high_in_first39", 32'(cnt), 32'd0);
        check("a5_rdy_cycle40", 32'(s_rdy0[39]), 32'd1);
        check("a5_busy_after_frame", 32'(s_busy[0][40]), 32'd0);
        check("even_parity_07", 32'(s_tx[1][37]), 32'd1);
        check("odd_parity_07", 32'(s_tx[2][37]), 32'd0);
        cnt = 0;
        for (int k = 0; k < 44; k++) cnt += s_busy[1][k] ? 1 : 0;
        check("even_frame_len", 32'(cnt), 32'(frame_len(CPB, DB, PAR_EVEN, 1)));
        cnt = 0;
        for (int k = 36; k < 44; k++) cnt += s_tx[3][k] ? 1 : 0;
        check("stop2_high_8", 32'(cnt), 32'd8);
        cnt = 0;
        for (int k = 0; k < 44; k++) cnt += s_busy[3][k] ? 1 : 0;
        check("stop2_frame_len", 32'(cnt), 32'd44);

        // --- back-to-back 0x00 then 0xFF on instance 0 ---
        repeat (3) @(posedge clk); #1;
        h0 = hs0;
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        wait_xfer(0);
        c1 = cyc;
        dat[0] = 8'hFF;
        wait_xfer(0);
        c2 = cyc;
        vld[0] = 1'b0;
        check("b2b_start_spacing", 32'(c2 - c1), 32'd40);
        repeat (50) @(posedge clk);
        check("b2b_two_transfers", 32'(hs0 - h0), 32'd2);

        // --- reset during data bit 3 ---
        @(posedge clk); #1;
        dat[0] = 8'hA5;
        vld[0] = 1'b1;
        wait_xfer(0);
        vld[0] = 1'b0;
        repeat (17) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_async", 32'(tx_w[0]), 32'd1);
        check("rst_busy_async", 32'(busy_w[0]), 32'd0);
        check("rst_rdy_async", 32'(rdy_w[0]), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rdy_low_until_edge", 32'(rdy_w[0]), 32'd0);
        repeat (3) @(posedge clk); #1;
        dat[0] = 8'h55;
        vld[0] = 1'b1;
        wait_xfer(0);
        vld[0] = 1'b0;
        repeat (45) @(posedge clk);

        // --- s_data scrambled every cycle, s_vld held, two frames each ---
        @(posedge clk); #1;
        b1 = xcnt[1]; b2 = xcnt[2]; b3 = xcnt[3];
        c1 = xcnt[0];
        vld = '1;
        for (int n = 0; n < 200; n++) begin
            for (int g = 0; g < N; g++) dat[g] = 8'($urandom);
            if (xcnt[0] >= c1 + 2 && xcnt[1] >= b1 + 2 && xcnt[2] >= b2 + 2 && xcnt[3] >= b3 + 2)
                break;
            @(posedge clk); #1;
        end
        vld = '0;
        check("scramble_two_frames", 32'(xcnt[3] >= b3 + 2), 32'd1);
        repeat (100) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule
